// File: rtl/mips_dmem_if.sv
// Load/store bus between the MIPS core (master) and its data-memory responder (slave).
interface mips_dmem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, size, unsigned_ld,
        input  ready, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, size, unsigned_ld,
        output ready, rdata, err
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// Data-memory responder: wait states, byte-lane store merge, load extension, internal RAM.
// Optional macro DMEM_MISALIGN_TRAP_EN faults misaligned halfword/word accesses instead of aligning them.
module mips_dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    mips_dmem_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;

    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q;

    logic        ready_q, ready_d, err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word_q;
    logic [ADDR_W-1:0] idx;
    logic        mem_we, fault;
    logic [3:0]  be;
    logic [31:0] wrep, merged, load_val;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        unused_addr_bits;

    assign idx              = addr_q[ADDR_W+1:2];
    assign unused_addr_bits = ^addr_q[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    // Lane selection ignores the offending low bits, which gives natural alignment for free.
    assign fault = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: if (bus.req) begin
                cnt_d   = 4'(WAIT_STATES);
                state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_ACCESS;
            end
            S_ACCESS: state_d = S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_q == S_IDLE) && bus.req;
        mem_we  = (state_q == S_RESP) && we_q && !fault;
        ready_d = (state_q == S_RESP);
        err_d   = (state_q == S_RESP) && fault;
        rdata_d = rdata_q;
        if ((state_q == S_RESP) && !we_q && !fault) rdata_d = load_val;
    end

    always_comb begin
        be     = 4'b0000;
        wrep   = '0;
        merged = rd_word_q;
        unique case (size_q)
            2'b00: begin
                be   = 4'b0001 << addr_q[1:0];
                wrep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_q[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = wdata_q;
            end
        endcase
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = wrep[8*i +: 8];
    end

    always_comb begin
        byte_v   = rd_word_q[{addr_q[1:0], 3'b000} +: 8];
        half_v   = addr_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        load_val = rd_word_q;
        unique case (size_q)
            2'b00:   load_val = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_val = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_val = rd_word_q;
        endcase
    end

    // Request fields are captured only at acceptance; pin activity afterwards is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.we;
            uns_q   <= bus.unsigned_ld;
            size_q  <= bus.size;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array has no reset so it maps onto plain synchronous RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= merged;
        rd_word_q <= mem[idx];
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
endmodule
